ecc_synd_check_array: RTL



---
 rtl/ecc_synd_check_array.sv | 113 +++++++++++
 1 files changed

// File: rtl/ecc_synd_check_array.sv
// Per-lane RS syndrome checker for the 16-lane byte-symbol ECC stream; 1-cycle pass-through with tlast and status handshake.
// Optional macro ECC_ERR_CNT_EN adds err_cnt/err_cnt_clr, a saturating count of codewords with any lane in error.
module ecc_synd_check_array #(
    parameter int CW_LEN = 255,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] axis_ins_tdata,
    input  logic         axis_ins_tvalid,
    output logic         axis_ins_tready,
    output logic [127:0] axis_ous_tdata,
    output logic         axis_ous_valid,
    output logic         axis_ous_last,
    input  logic         axis_ous_ready,
    output logic         stat_valid,
    output logic [15:0]  stat_err_mask,
    input  logic         stat_ready
`ifdef ECC_ERR_CNT_EN
    ,
    input  logic         err_cnt_clr,
    output logic [31:0]  err_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_LEN - 1);

    function automatic logic [7:0] mul_alpha(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
    endfunction

    logic [CNT_W-1:0]  cnt;
    logic [15:0][7:0]  s0;
    logic [15:0][7:0]  s1;
    logic [15:0][7:0]  s0_nxt;
    logic [15:0][7:0]  s1_nxt;
    logic [15:0]       mask_nxt;
    logic              accept;
    logic              cnt_first;
    logic              cnt_last;

    assign cnt_first = (cnt == '0);
    assign cnt_last  = (cnt == LAST_CNT);

    // The first beat of a codeword waits until the previous result is taken.
    assign axis_ins_tready = (!axis_ous_valid || axis_ous_ready) && !(stat_valid && cnt_first);
    assign accept          = axis_ins_tvalid && axis_ins_tready;

    always_comb begin
        s0_nxt   = s0;
        s1_nxt   = s1;
        mask_nxt = '0;
        for (int i = 0; i < 16; i++) begin
            if (cnt_first) begin
                s0_nxt[i] = axis_ins_tdata[8*i +: 8];
                s1_nxt[i] = axis_ins_tdata[8*i +: 8];
            end else begin
                s0_nxt[i] = s0[i] ^ axis_ins_tdata[8*i +: 8];
                s1_nxt[i] = mul_alpha(s1[i]) ^ axis_ins_tdata[8*i +: 8];
            end
            mask_nxt[i] = |(s0_nxt[i] | s1_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            s0             <= '0;
            s1             <= '0;
            axis_ous_tdata <= '0;
            axis_ous_valid <= 1'b0;
            axis_ous_last  <= 1'b0;
        end else begin
            if (accept) begin
                cnt            <= cnt_last ? '0 : cnt + 1'b1;
                s0             <= s0_nxt;
                s1             <= s1_nxt;
                axis_ous_tdata <= axis_ins_tdata;
                axis_ous_valid <= 1'b1;
                axis_ous_last  <= cnt_last;
            end else if (axis_ous_ready) begin
                axis_ous_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_valid    <= 1'b0;
            stat_err_mask <= '0;
        end else begin
            if (accept && cnt_last) begin
                stat_valid    <= 1'b1;
                stat_err_mask <= mask_nxt;
            end else if (stat_valid && stat_ready) begin
                stat_valid <= 1'b0;
            end
        end
    end

`ifdef ECC_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (accept && cnt_last && (|mask_nxt) && (err_cnt != 32'hFFFF_FFFF)) begin
            err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule
